// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: FWD/ADD/AND/OR in one step, bit-serial shifts/rotate, shift-add multiply.
// Latency: N+1 edges from accepted start to the DONE cycle (N = 1, shift amount, or 8 for MUL).
// Backpressure: start is ignored while busy; outputs hold until the next completion.
//
// Ports:
//   clk_i            sole clock, rising edge
//   rst_ni           synchronous active-low reset
//   start_i          request, sampled in IDLE or DONE only
//   opcode_i [2:0]   000 FWD, 001 ADD, 010 AND, 011 OR, 100 SLL, 101 SRA, 110 ROR, 111 MUL
//   data1_i, data2_i operands
//   busy_o           high while executing
//   done_o           one-cycle completion pulse
//   result_o, zero_o, ovf_o  registered results, updated only on entry to DONE
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       opcode_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_ROR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;       // working value for shifts/rotate, operand A otherwise
    logic [WIDTH-1:0]     b_q;       // operand B; shifted right one bit per MUL step
    logic [2*WIDTH-1:0]   mcand_q;   // multiplicand, shifted left one bit per MUL step
    logic [2*WIDTH-1:0]   acc_q;     // partial product
    logic [3:0]           cnt_q;     // steps remaining
    logic                 noop_q;    // zero shift/rotate amount: single identity step
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 ovf_q;

    // Start-time step count
    logic [3:0] amt_sh;
    logic [3:0] amt_d;
    logic       noop_d;
    logic [3:0] cnt_d;

    always_comb begin
        amt_sh = (data2_i >= WIDTH'(8)) ? 4'd8 : data2_i[3:0];
        amt_d  = 4'd1;
        case (opcode_i)
            OP_SLL, OP_SRA: amt_d = amt_sh;
            OP_ROR:         amt_d = {1'b0, data2_i[2:0]};
            OP_MUL:         amt_d = 4'd8;
            default:        amt_d = 4'd1;
        endcase
        noop_d = (amt_d == 4'd0);
        cnt_d  = noop_d ? 4'd1 : amt_d;
    end

    // One execution step
    logic [WIDTH-1:0]   work_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   res_d;
    logic               ovf_d;

    always_comb begin
        work_d = a_q;
        acc_d  = acc_q + (b_q[0] ? mcand_q : '0);
        case (op_q)
            OP_FWD: work_d = b_q;
            OP_ADD: work_d = a_q + b_q;
            OP_AND: work_d = a_q & b_q;
            OP_OR:  work_d = a_q | b_q;
            OP_SLL: if (!noop_q) work_d = {a_q[WIDTH-2:0], 1'b0};
            OP_SRA: if (!noop_q) work_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            OP_ROR: if (!noop_q) work_d = {a_q[0], a_q[WIDTH-1:1]};
            default: work_d = a_q;
        endcase
        res_d = (op_q == OP_MUL) ? acc_d[WIDTH-1:0] : work_d;
        ovf_d = (op_q == OP_MUL) && (|acc_d[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= OP_FWD;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            noop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q    <= opcode_i;
                        a_q     <= data1_i;
                        b_q     <= data2_i;
                        mcand_q <= {{WIDTH{1'b0}}, data1_i};
                        acc_q   <= '0;
                        cnt_q   <= cnt_d;
                        noop_q  <= noop_d;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    a_q     <= work_d;
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    if (op_q == OP_MUL) begin
                        b_q <= b_q >> 1;
                    end
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        result_q <= res_d;
                        zero_q   <= (res_d == '0);
                        ovf_q    <= ovf_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with hand-computed expected results.
// Latency: checks busy-cycle count per operation against the expected step count.
// Backpressure: exercises start during execution and start held in DONE.
module tb_alu_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [2:0] opcode_i;
    logic [7:0] data1_i;
    logic [7:0] data2_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] result_o;
    logic       zero_o;
    logic       ovf_o;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_ROR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    alu_sequencer #(.WIDTH(8)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .opcode_i (opcode_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and clock it in (the acceptance edge).
    task automatic start_op(input logic [2:0] opc, input logic [7:0] d1, input logic [7:0] d2);
        opcode_i = opc;
        data1_i  = d1;
        data2_i  = d2;
        start_i  = 1'b1;
        tick();
    endtask

    // Called in the first busy cycle; counts busy cycles and checks the DONE cycle.
    task automatic wait_done(input string tag, input int exp_n, input logic [7:0] exp_res,
                             input logic exp_ovf);
        int n = 0;
        int overlap = 0;
        int leaked = 0;
        logic [7:0] prev = result_o;
        while (busy_o && n < 20) begin
            if (done_o) overlap++;
            if (result_o !== prev) leaked++;
            tick();
            n++;
        end
        check({tag, " busy_cycles"}, 16'(n), 16'(exp_n));
        check({tag, " busy_done_overlap"}, 16'(overlap), 16'd0);
        check({tag, " result_held_while_busy"}, 16'(leaked), 16'd0);
        check({tag, " done"}, {15'd0, done_o}, 16'd1);
        check({tag, " result"}, {8'd0, result_o}, {8'd0, exp_res});
        check({tag, " zero"}, {15'd0, zero_o}, {15'd0, (exp_res == 8'h00)});
        check({tag, " ovf"}, {15'd0, ovf_o}, {15'd0, exp_ovf});
    endtask

    task automatic run_op(input string tag, input logic [2:0] opc, input logic [7:0] d1,
                          input logic [7:0] d2, input int exp_n, input logic [7:0] exp_res,
                          input logic exp_ovf);
        start_op(opc, d1, d2);
        start_i = 1'b0;
        wait_done(tag, exp_n, exp_res, exp_ovf);
        tick();
        check({tag, " idle_after_done"}, {14'd0, busy_o, done_o}, 16'd0);
    endtask

    initial begin
        int dones;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        opcode_i = OP_FWD;
        data1_i  = 8'h00;
        data2_i  = 8'h00;
        tick();
        tick();
        check("reset busy/done", {14'd0, busy_o, done_o}, 16'd0);
        check("reset result", {8'd0, result_o}, 16'h0000);
        check("reset zero/ovf", {14'd0, zero_o, ovf_o}, 16'b10);

        // Start present on the first edge with reset released must be accepted.
        rst_ni = 1'b1;
        run_op("ADD 05+03", OP_ADD, 8'h05, 8'h03, 1, 8'h08, 1'b0);
        run_op("ADD FF+01", OP_ADD, 8'hFF, 8'h01, 1, 8'h00, 1'b0);
        run_op("AND F0&3C", OP_AND, 8'hF0, 8'h3C, 1, 8'h30, 1'b0);
        run_op("OR F0|0C",  OP_OR,  8'hF0, 8'h0C, 1, 8'hFC, 1'b0);
        run_op("FWD A5",    OP_FWD, 8'h12, 8'hA5, 1, 8'hA5, 1'b0);
        run_op("SRA 80>>3", OP_SRA, 8'h80, 8'h03, 3, 8'hF0, 1'b0);
        run_op("SRA 7F>>9", OP_SRA, 8'h7F, 8'h09, 8, 8'h00, 1'b0);
        run_op("SRA 81>>C8", OP_SRA, 8'h81, 8'hC8, 8, 8'hFF, 1'b0);
        run_op("SLL 81<<10", OP_SLL, 8'h81, 8'h0A, 8, 8'h00, 1'b0);
        run_op("SLL 81<<3", OP_SLL, 8'h81, 8'h03, 3, 8'h08, 1'b0);
        run_op("SLL 81<<0", OP_SLL, 8'h81, 8'h00, 1, 8'h81, 1'b0);
        run_op("ROR 81 by 1", OP_ROR, 8'h81, 8'h01, 1, 8'hC0, 1'b0);
        run_op("ROR 81 by 8", OP_ROR, 8'h81, 8'h08, 1, 8'h81, 1'b0);
        run_op("ROR 81 by 3", OP_ROR, 8'h81, 8'h03, 3, 8'h30, 1'b0);
        run_op("MUL 10*11", OP_MUL, 8'h10, 8'h11, 8, 8'h10, 1'b1);
        run_op("MUL 0F*11", OP_MUL, 8'h0F, 8'h11, 8, 8'hFF, 1'b0);
        run_op("MUL 0D*0B", OP_MUL, 8'h0D, 8'h0B, 8, 8'h8F, 1'b0);

        // New request during MUL execution is ignored; start held in DONE
        // launches the next operation with no idle cycle.
        start_op(OP_MUL, 8'h10, 8'h11);
        opcode_i = OP_ADD;
        data1_i  = 8'h22;
        data2_i  = 8'h33;
        wait_done("MUL ignore start", 8, 8'h10, 1'b1);
        tick();
        check("b2b busy", {14'd0, busy_o, done_o}, 16'b10);
        start_i = 1'b0;
        wait_done("b2b ADD 22+33", 1, 8'h55, 1'b0);
        tick();

        // Reset on MUL step 4 aborts with no DONE pulse.
        start_op(OP_MUL, 8'h0F, 8'h11);
        start_i = 1'b0;
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        tick();
        check("abort busy/done", {14'd0, busy_o, done_o}, 16'd0);
        check("abort result", {8'd0, result_o}, 16'h0000);
        check("abort zero/ovf", {14'd0, zero_o, ovf_o}, 16'b10);
        rst_ni = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_o || busy_o) dones++;
            tick();
        end
        check("abort no later activity", 16'(dones), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; only 8 is supported and verified.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset; synchronous and active-low.
REQ-004 START  input  1  request; sampled only in IDLE or DONE state.
REQ-005 OPCODE  input  3  000 FWD(DATA2), 001 ADD, 010 AND, 011 OR, 100 SLL, 101 SRA, 110 ROR, 111 MUL.
REQ-006 DATA1  input  8  first operand / shift source / multiplicand.
REQ-007 DATA2  input  8  second operand / shift amount (unsigned) / multiplier.
REQ-008 BUSY  output  1  high while in EXEC state.
REQ-009 DONE  output  1  one-cycle completion pulse (high in DONE state only).
REQ-010 RESULT  output  8  registered result; holds value until next completion.
REQ-011 ZERO  output  1  registered; 1 iff RESULT == 0x00.
REQ-012 OVF  output  1  registered; MUL only: 1 iff 16-bit product > 0xFF; 0 for all other opcodes.

Function
REQ-013 States SHALL be IDLE, EXEC, DONE; only these three are reachable.
REQ-014 IDLE or DONE with START=1 at edge k: latch OPCODE, DATA1, DATA2 and step count N; next state EXEC.
REQ-015 DONE with START=0: next state IDLE; IDLE with START=0: stay IDLE.
REQ-016 START in EXEC SHALL be ignored; latched operands SHALL NOT change while BUSY.
REQ-017 EXEC performs one step per edge; after the N-th step (edge k+N) next state DONE; DONE=1 and RESULT/ZERO/OVF valid during the cycle following edge k+N.
REQ-018 N = 1 for FWD, ADD, AND, OR; result computed modulo 256 (ADD carry discarded).
REQ-019 SLL/SRA: amount A = min(DATA2, 8); N = max(A, 1); each step shifts 1 bit (SLL fills 0, SRA replicates bit 7); A = 0 returns DATA1 unchanged.
REQ-020 SLL with DATA2 >= 8 SHALL yield 0x00; SRA with DATA2 >= 8 SHALL yield 0x00 or 0xFF per DATA1[7].
REQ-021 ROR: amount A = DATA2[2:0]; N = max(A, 1); each step rotates right 1 bit; A = 0 returns DATA1.
REQ-022 MUL: N = 8; unsigned shift-add, one multiplier bit per step; RESULT = product[7:0], OVF = |product[15:8].
REQ-023 RESULT, ZERO, OVF SHALL update only on the edge entering DONE; intermediate values SHALL NOT appear on RESULT.
REQ-024 BUSY and DONE SHALL never be high simultaneously.
REQ-025 Back-to-back: START=1 in DONE SHALL start the next operation with no IDLE cycle.

Reset
REQ-026 RESET=0 at an edge: state IDLE, BUSY=0, DONE=0, RESULT=0x00, ZERO=1, OVF=0, internal counters/accumulators cleared.
REQ-027 RESET=0 overrides START and any in-flight operation; aborted operation SHALL produce no DONE pulse.
REQ-028 START sampled on the first edge with RESET=1 SHALL be accepted.

Verification
REQ-029 ADD 0x05,0x03 -> BUSY 1 cycle, DONE next cycle, RESULT 0x08, ZERO 0; ADD 0xFF,0x01 -> RESULT 0x00, ZERO 1, OVF 0.
REQ-030 SRA 0x80 by 3 -> BUSY 3 cycles, RESULT 0xF0; SLL 0x81 by 10 -> BUSY 8 cycles, RESULT 0x00, ZERO 1.
REQ-031 ROR 0x81 by 1 -> RESULT 0xC0; ROR 0x81 by 8 -> BUSY 1 cycle, RESULT 0x81.
REQ-032 MUL 0x10,0x11 -> BUSY 8 cycles, RESULT 0x10, OVF 1; MUL 0x0F,0x11 -> RESULT 0xFF, OVF 0.
REQ-033 START with new operands during MUL EXEC -> ignored, original MUL result delivered; START held in DONE -> next op enters EXEC immediately.
REQ-034 RESET=0 at MUL step 4 -> next cycle BUSY 0, DONE 0, RESULT 0x00, ZERO 1, OVF 0; no DONE pulse afterward.
